// File: rtl/qkd_pkg.sv
// Shared types and constants for the BB84 polarisation encoder.
// Polarisation codes are indexed by {bit, base}.
package qkd_pkg;

    typedef logic [1:0] qubit_t;

    localparam qubit_t ZERO         = 2'b00;
    localparam qubit_t NINETY       = 2'b01;
    localparam qubit_t FORTYFIVE    = 2'b10;
    localparam qubit_t ONETHREEFIVE = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/qubit_lane_enc.sv
// Combinational single-qubit encoder: {bit, base} -> polarisation code.
module qubit_lane_enc
    import qkd_pkg::*;
(
    input  logic   r_bit_i,
    input  logic   r_base_i,
    output qubit_t qubit_o
);

    always_comb begin
        qubit_o = ZERO;
        unique case ({r_bit_i, r_base_i})
            2'b00:   qubit_o = ZERO;
            2'b10:   qubit_o = NINETY;
            2'b01:   qubit_o = FORTYFIVE;
            2'b11:   qubit_o = ONETHREEFIVE;
            default: qubit_o = ZERO;
        endcase
    end

endmodule

// File: rtl/qubit_stream_encoder.sv
// Streaming BB84 encoder: accepts a frame of bits/bases, emits LANES codes per beat.
// Optional per-frame basis statistics are enabled by defining QKD_BASIS_STATS_EN.
module qubit_stream_encoder
    import qkd_pkg::*;
#(
    parameter int unsigned KEY_BITS = 640,
    parameter int unsigned LANES    = 8,
    localparam int unsigned BEATS   = KEY_BITS / LANES,
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned STAT_W  = $clog2(KEY_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [KEY_BITS-1:0]   r_bit,
    input  logic [KEY_BITS-1:0]   r_base,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*LANES-1:0]    out_qubits,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last
`ifdef QKD_BASIS_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_z_count,
    output logic [STAT_W-1:0]     stat_x_count,
    output logic                  stat_valid
`endif
);

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [2*LANES-1:0]    qubits_q, qubits_d;
    logic [BEAT_W-1:0]     beat_q, beat_d, beat_inc;
    logic [KEY_BITS-1:0]   bit_q, bit_d, base_q, base_d;

    logic [LANES-1:0]      lane_bit, lane_base;
    logic [2*LANES-1:0]    lane_code;
    logic                  accept, xfer;

    // Frame registers shift down one beat per transfer, so the encoders always read lane 0..LANES-1.
    always_comb begin
        lane_bit  = (state_q == IDLE) ? r_bit[LANES-1:0]  : bit_q[LANES-1:0];
        lane_base = (state_q == IDLE) ? r_base[LANES-1:0] : base_q[LANES-1:0];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        qubit_lane_enc u_enc (
            .r_bit_i  (lane_bit[k]),
            .r_base_i (lane_base[k]),
            .qubit_o  (lane_code[2*k +: 2])
        );
    end

    assign accept   = (state_q == IDLE) && in_ready_q && in_valid && !abort;
    assign xfer     = out_valid_q && out_ready;
    assign beat_inc = beat_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        qubits_d    = qubits_q;
        beat_d      = beat_q;
        bit_d       = bit_q;
        base_d      = base_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    state_d     = SEND;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_last_d  = (BEATS == 1);
                    qubits_d    = lane_code;
                    beat_d      = '0;
                    bit_d       = r_bit >> LANES;
                    base_d      = r_base >> LANES;
                end
            end
            SEND: begin
                if (abort || (xfer && out_last_q)) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    qubits_d    = '0;
                    beat_d      = '0;
                end else if (xfer) begin
                    beat_d     = beat_inc;
                    out_last_d = (beat_inc == BEAT_W'(BEATS - 1));
                    qubits_d   = lane_code;
                    bit_d      = bit_q >> LANES;
                    base_d     = base_q >> LANES;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            qubits_q    <= '0;
            beat_q      <= '0;
            bit_q       <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            qubits_q    <= qubits_d;
            beat_q      <= beat_d;
            bit_q       <= bit_d;
            base_q      <= base_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_qubits = qubits_q;
    assign out_beat   = beat_q;

`ifdef QKD_BASIS_STATS_EN
    logic [STAT_W-1:0] z_q, z_d, x_q, x_d, base_ones;
    logic              stat_valid_q, stat_valid_d;

    // The upper bit of each code is the base, so counts come straight from the beat on the wire.
    always_comb begin
        base_ones = '0;
        for (int k = 0; k < LANES; k++) begin
            base_ones = base_ones + STAT_W'(qubits_q[2*k+1]);
        end
        z_d          = z_q;
        x_d          = x_q;
        stat_valid_d = 1'b0;
        if (accept || (state_q == SEND && abort)) begin
            z_d = '0;
            x_d = '0;
        end else if (state_q == SEND && xfer) begin
            x_d          = x_q + base_ones;
            z_d          = z_q + (STAT_W'(LANES) - base_ones);
            stat_valid_d = out_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q          <= '0;
            x_q          <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            z_q          <= z_d;
            x_q          <= x_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_z_count = z_q;
    assign stat_x_count = x_q;
    assign stat_valid   = stat_valid_q;
`endif

endmodule

// File: tb/tb_qubit_stream_encoder.sv
// Directed bench for qubit_stream_encoder (KEY_BITS=16, LANES=4); stats checks under QKD_BASIS_STATS_EN.
module tb_qubit_stream_encoder;

    localparam int unsigned KB = 16;
    localparam int unsigned LN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] r_bit;
    logic [15:0] r_base;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_qubits;
    logic [1:0]  out_beat;
    logic        out_last;
`ifdef QKD_BASIS_STATS_EN
    logic [4:0]  stat_z_count;
    logic [4:0]  stat_x_count;
    logic        stat_valid;
`endif

    int checks   = 0;
    int failures = 0;

    qubit_stream_encoder #(
        .KEY_BITS (KB),
        .LANES    (LN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .r_bit      (r_bit),
        .r_base     (r_base),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_qubits (out_qubits),
        .out_beat   (out_beat),
        .out_last   (out_last)
`ifdef QKD_BASIS_STATS_EN
        ,
        .stat_z_count (stat_z_count),
        .stat_x_count (stat_x_count),
        .stat_valid   (stat_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        logic [15:0] bases;
        logic [31:0] beats;  // beat i in bits [8*i +: 8]
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer a frame and wait (bounded) for it to be accepted; ends at a negedge.
    task automatic start_frame(input logic [15:0] bits, input logic [15:0] bases, input bit keep);
        r_bit    = bits;
        r_base   = bases;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("accept_valid", {31'b0, out_valid}, 32'd1);
        check("accept_in_ready", {31'b0, in_ready}, 32'd0);
        check("accept_beat0", {30'b0, out_beat}, 32'd0);
        if (!keep) in_valid = 1'b0;
        r_bit  = ~bits;
        r_base = bits ^ bases;
    endtask

    // Drain four beats, stalling stall cycles before each transfer; ends at negedge after last transfer.
    task automatic run_beats(input logic [31:0] exp, input int stall);
        for (int idx = 0; idx < 4; idx++) begin
            for (int s = 0; s <= stall; s++) begin
                check("beat_valid", {31'b0, out_valid}, 32'd1);
                check("beat_qubits", {24'b0, out_qubits}, {24'b0, exp[8*idx +: 8]});
                check("beat_index", {30'b0, out_beat}, idx);
                check("beat_last", {31'b0, out_last}, (idx == 3) ? 32'd1 : 32'd0);
                check("beat_in_ready", {31'b0, in_ready}, 32'd0);
                out_ready = (s == stall);
                @(negedge clk);
            end
        end
        check("end_valid", {31'b0, out_valid}, 32'd0);
        check("end_last", {31'b0, out_last}, 32'd0);
        check("end_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{bits: 16'h000F, bases: 16'h0033, beats: 32'h00_00_0A_5F};
        vecs[1] = '{bits: 16'hFFFF, bases: 16'h0000, beats: 32'h55_55_55_55};
        vecs[2] = '{bits: 16'h0000, bases: 16'hFFFF, beats: 32'hAA_AA_AA_AA};
        vecs[3] = '{bits: 16'hFFFF, bases: 16'hFFFF, beats: 32'hFF_FF_FF_FF};
        vecs[4] = '{bits: 16'h1234, bases: 16'h8421, beats: 32'h81_24_0D_12};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        r_bit     = '0;
        r_base    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_qubits", {24'b0, out_qubits}, 32'd0);
        check("rst_beat", {30'b0, out_beat}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("release_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("release_in_ready_high", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].bits, vecs[i].bases, 1'b0);
            run_beats(vecs[i].beats, 0);
        end

        // Backpressure: two stall cycles before every transfer.
        start_frame(vecs[4].bits, vecs[4].bases, 1'b0);
        run_beats(vecs[4].beats, 2);

        // Back-to-back frames with in_valid held; one bubble between them.
        start_frame(vecs[0].bits, vecs[0].bases, 1'b1);
        r_bit  = vecs[4].bits;
        r_base = vecs[4].bases;
        run_beats(vecs[0].beats, 0);
        @(negedge clk);
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        run_beats(vecs[4].beats, 0);

        // Abort during beat 2.
        start_frame(vecs[4].bits, vecs[4].bases, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_at_beat2", {30'b0, out_beat}, 32'd2);
        out_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_beat", {30'b0, out_beat}, 32'd0);

        // Abort in idle blocks a simultaneous frame offer.
        abort    = 1'b1;
        in_valid = 1'b1;
        r_bit    = vecs[0].bits;
        r_base   = vecs[0].bases;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("idle_abort_no_accept", {31'b0, out_valid}, 32'd0);
        check("idle_abort_in_ready", {31'b0, in_ready}, 32'd1);
        start_frame(vecs[0].bits, vecs[0].bases, 1'b0);
        run_beats(vecs[0].beats, 0);

        // Abort coinciding with the last-beat transfer.
        start_frame(vecs[1].bits, vecs[1].bases, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_last_is_last", {31'b0, out_last}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_last_valid", {31'b0, out_valid}, 32'd0);
        check("abort_last_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_last_last", {31'b0, out_last}, 32'd0);
`ifdef QKD_BASIS_STATS_EN
        check("abort_no_stat", {31'b0, stat_valid}, 32'd0);
        @(negedge clk);
        check("abort_no_stat_late", {31'b0, stat_valid}, 32'd0);
`endif

        // Asynchronous reset mid-frame.
        start_frame(vecs[3].bits, vecs[3].bases, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_qubits", {24'b0, out_qubits}, 32'd0);
        check("midrst_beat", {30'b0, out_beat}, 32'd0);
        check("midrst_last", {31'b0, out_last}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_release_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("midrst_release_high", {31'b0, in_ready}, 32'd1);
        start_frame(vecs[2].bits, vecs[2].bases, 1'b0);
        run_beats(vecs[2].beats, 0);

`ifdef QKD_BASIS_STATS_EN
        start_frame(16'h0000, 16'h00FF, 1'b0);
        check("stat_clear_z", {27'b0, stat_z_count}, 32'd0);
        check("stat_clear_x", {27'b0, stat_x_count}, 32'd0);
        run_beats(32'h00_00_AA_AA, 0);
        check("stat_pulse", {31'b0, stat_valid}, 32'd1);
        check("stat_z", {27'b0, stat_z_count}, 32'd8);
        check("stat_x", {27'b0, stat_x_count}, 32'd8);
        @(negedge clk);
        check("stat_pulse_end", {31'b0, stat_valid}, 32'd0);
        check("stat_z_hold", {27'b0, stat_z_count}, 32'd8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
